loop_nest_counter: RTL and testbench
====================================

Name: loop_nest_counter

Overview:
Parametrised multi-dimensional loop-index generator. It is the successor to the single-dimension wrap counter and drives CNN tile loops (e.g. output-channel / row / column / kernel).
- Counts NUM_DIMS nested indices, each from 0 to a run-time bound.
- Each index tuple is issued through a valid/ready handshake.
- Signals per-dimension wrap and a one-cycle done pulse.
- Sits between the layer controller (start, bounds) and the address generators / PE array sequencer (indices).

Parameters:
NUM_DIMS, 4, number of nested loop dimensions; dim 0 is innermost (fastest).
COUNTER_WIDTH, 8, width of each index and bound.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  launch a loop nest; sampled only in IDLE.
bound  input  NUM_DIMS*COUNTER_WIDTH  per-dim last index value; dim d at bits [d*W +: W]; latched on accepted start.
idx_ready  input  1  consumer accepts the current tuple.
idx  output  NUM_DIMS*COUNTER_WIDTH  current index tuple, same packing as bound.
idx_valid  output  1  idx is valid.
wrap  output  NUM_DIMS  wrap[d]=1 when idx[0..d] all equal their latched bounds (dim d closes on this beat).
busy  output  1  high in RUN.
done  output  1  one-cycle pulse after the final tuple is accepted.

Behaviour:
- Reset: state=IDLE. idx=0, idx_valid=0, busy=0, done=0, latched bounds=0, wrap=0.
- States: IDLE, RUN.
- IDLE:
  - start=1 latches bound, zeroes idx, and moves to RUN next cycle.
  - idx_valid=1 on the first RUN cycle, so first-tuple latency is 1 cycle from start.
  - wrap is forced to 0 in IDLE.
- RUN:
  - idx_valid=1 continuously; busy=1.
  - Beat = idx_valid & idx_ready.
  - No beat: idx and wrap are held stable; the consumer may stall indefinitely.
  - Beat with wrap[NUM_DIMS-1]=0: dim 0 increments. Every dim d with wrap[d]=1 resets to 0, and dim d+1 increments when wrap[d]=1 (ripple carry).
  - Beat with wrap[NUM_DIMS-1]=1: final tuple. Next cycle state=IDLE, idx=0, idx_valid=0, done=1 for exactly one cycle.
- wrap is combinational from idx and latched bounds. wrap[d] = wrap[d-1] & (idx[d]==bound_q[d]); wrap[0] = (idx[0]==bound_q[0]).
- Bound 0 for a dim means one iteration; that dim is always at bound.
- Tuples issued = product over d of (bound[d]+1).
- Ordering: strict row-major, innermost dim fastest. No tuple is skipped or repeated regardless of ready pattern.
- start during RUN: ignored. bound changes during RUN: ignored (latched copy used).
- start in the same cycle as done: accepted, since the state is IDLE then.
- Back-to-back nests: minimum one idle cycle between the final beat and the next first tuple.
- reset mid-RUN: next cycle is the reset state; no done pulse.
- Arithmetic:
  - Unsigned, COUNTER_WIDTH bits per dim.
  - Increment never overflows, because wrap resets at the bound.
  - bound=2^W-1 is a legal maximum.

Optional Feature:
Macro LOOP_NEST_COUNTER_FLAT_EN.
- Defined: adds output flat_idx (NUM_DIMS*COUNTER_WIDTH bits, unsigned).
  - Linear count of the current tuple: 0 at the first tuple, +1 per beat.
  - Reset and return to IDLE set it to 0.
  - Held on stall.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package loop_nest_counter_pkg:
  - state enum {IDLE, RUN}.
  - Default NUM_DIMS/COUNTER_WIDTH constants.
  - Helper function for packed-field slice index.
- Sub-module loop_dim_counter: one dimension.
  - Inputs: clk, reset, clear, inc, bound_q.
  - Outputs: idx, at_bound.
  - Instantiated NUM_DIMS times via generate; the top chains at_bound into wrap and inc.

Test Plan:
- Reset then idle, start=0 for 10 cycles -> idx_valid=0, busy=0, done=0, idx=0 throughout.
- NUM_DIMS=4, bound={1,2,0,3} (dim3..dim0), ready=1 -> 24 tuples in row-major order. wrap[0] every 4th beat. wrap[3] only on tuple {1,2,0,3}. done pulses 1 cycle after it; flat_idx runs 0..23 when the macro is defined.
- Same bounds, ready randomly low ~50% -> identical tuple sequence; idx stable while ready=0; no duplicates or skips.
- All bounds 0 -> exactly one tuple {0,0,0,0} with wrap=4'b1111, then done; start asserted on the done cycle -> new nest's first tuple appears next cycle.
- bound dim0=255 (max), others 0 -> 256 tuples, no overflow; final idx[0]=255 with wrap[3]=1.
- reset asserted mid-RUN at tuple 5 -> next cycle idx_valid=0, idx=0, busy=0, no done; a subsequent start restarts from {0,0,0,0}.

Source files
------------

// File: rtl/loop_nest_counter_pkg.sv
// -----------------------------------------------------------------------------
// loop_nest_counter_pkg
// Shared types and helpers for the loop-nest index generator.
//   state_t               : controller state (IDLE, RUN)
//   DEFAULT_NUM_DIMS      : default number of nested dimensions
//   DEFAULT_COUNTER_WIDTH : default width of each index / bound field
//   field_lsb()           : LSB position of dimension d in a packed tuple
// -----------------------------------------------------------------------------
package loop_nest_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_DIMS      = 4;
    localparam int DEFAULT_COUNTER_WIDTH = 8;

    // Dimension d occupies bits [d*w +: w] of every packed tuple.
    function automatic int field_lsb(input int d, input int w);
        return d * w;
    endfunction

endpackage

// File: rtl/loop_dim_counter.sv
// -----------------------------------------------------------------------------
// loop_dim_counter
// One dimension of the loop nest: an index that counts 0..bound_q and
// returns to 0 on the step taken while it sits at its bound.
// Ports:
//   clk      : clock, posedge
//   reset    : synchronous active-high reset (idx -> 0)
//   clear    : force idx to 0 (launch of a nest / end of a nest)
//   inc      : advance this dimension by one step
//   bound_q  : latched last index value for this dimension
//   idx      : current index
//   at_bound : idx equals bound_q
// -----------------------------------------------------------------------------
module loop_dim_counter
    import loop_nest_counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     inc,
    input  logic [COUNTER_WIDTH-1:0] bound_q,
    output logic [COUNTER_WIDTH-1:0] idx,
    output logic                     at_bound
);

    assign at_bound = (idx == bound_q);

    // Wrapping at the bound means the increment can never overflow,
    // even when the bound is the all-ones maximum.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
        end else if (inc) begin
            if (at_bound) begin
                idx <= '0;
            end else begin
                idx <= idx + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// -----------------------------------------------------------------------------
// loop_nest_counter
// Multi-dimensional loop-index generator for CNN tile loops. Issues every
// index tuple of a NUM_DIMS-deep nest (dim 0 innermost) in row-major order
// over a valid/ready handshake, flags per-dimension wraps, and pulses done
// once the final tuple has been accepted.
// Optional build macro: LOOP_NEST_COUNTER_FLAT_EN adds flat_idx, the linear
// ordinal of the current tuple.
// Ports:
//   clk       : clock, posedge
//   reset     : synchronous active-high reset
//   start     : launch a nest (sampled only in IDLE)
//   bound     : per-dim last index, dim d at [d*W +: W]; latched on launch
//   idx_ready : consumer accepts the current tuple
//   idx       : current index tuple, same packing as bound
//   idx_valid : idx is valid (high throughout RUN)
//   wrap      : wrap[d] = dims 0..d all at their bounds (forced 0 in IDLE)
//   busy      : high in RUN
//   done      : one-cycle pulse after the final tuple is accepted
//   flat_idx  : (LOOP_NEST_COUNTER_FLAT_EN only) linear tuple count
// -----------------------------------------------------------------------------
module loop_nest_counter
    import loop_nest_counter_pkg::*;
#(
    parameter int NUM_DIMS      = DEFAULT_NUM_DIMS,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_DIMS*COUNTER_WIDTH-1:0] bound,
    input  logic                              idx_ready,
    output logic [NUM_DIMS*COUNTER_WIDTH-1:0] idx,
    output logic                              idx_valid,
    output logic [NUM_DIMS-1:0]               wrap,
    output logic                              busy,
    output logic                              done
`ifdef LOOP_NEST_COUNTER_FLAT_EN
    ,
    output logic [NUM_DIMS*COUNTER_WIDTH-1:0] flat_idx
`endif
);

    localparam int NW = NUM_DIMS * COUNTER_WIDTH;

    state_t               state;
    logic [NW-1:0]        bound_q;
    logic [NUM_DIMS-1:0]  at_bound;
    logic [NUM_DIMS-1:0]  wrap_raw;
    logic [NUM_DIMS-1:0]  inc;
    logic                 run;
    logic                 beat;
    logic                 final_beat;
    logic                 launch;
    logic                 clear;

    assign run        = (state == RUN);
    assign beat       = run & idx_ready;
    assign final_beat = beat & wrap_raw[NUM_DIMS-1];
    assign launch     = ~run & start;
    assign clear      = launch | final_beat;

    // Ripple carry: a dimension steps only when every inner dimension
    // closes on this beat.
    always_comb begin
        wrap_raw    = '0;
        inc         = '0;
        wrap_raw[0] = at_bound[0];
        for (int d = 1; d < NUM_DIMS; d++) begin
            wrap_raw[d] = wrap_raw[d-1] & at_bound[d];
        end
        inc[0] = beat;
        for (int d = 1; d < NUM_DIMS; d++) begin
            inc[d] = beat & wrap_raw[d-1];
        end
    end

    assign wrap      = run ? wrap_raw : '0;
    assign idx_valid = run;
    assign busy      = run;

    for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
        loop_dim_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_dim (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .inc      (inc[d]),
            .bound_q  (bound_q[field_lsb(d, COUNTER_WIDTH) +: COUNTER_WIDTH]),
            .idx      (idx[field_lsb(d, COUNTER_WIDTH) +: COUNTER_WIDTH]),
            .at_bound (at_bound[d])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bound_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= final_beat;
            case (state)
                IDLE: begin
                    if (start) begin
                        bound_q <= bound;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (final_beat) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOOP_NEST_COUNTER_FLAT_EN
    localparam logic [NW-1:0] FLAT_ONE = NW'(1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            flat_idx <= '0;
        end else if (beat) begin
            flat_idx <= flat_idx + FLAT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_loop_nest_counter.sv
module tb_loop_nest_counter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] bound = '0;
    logic          idx_ready = 1'b0;
    logic [NW-1:0] idx;
    logic          idx_valid;
    logic [N-1:0]  wrap;
    logic          busy;
    logic          done;
`ifdef LOOP_NEST_COUNTER_FLAT_EN
    logic [NW-1:0] flat_idx;
`endif

    always #5 clk = ~clk;

    loop_nest_counter #(
        .NUM_DIMS      (N),
        .COUNTER_WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bound     (bound),
        .idx_ready (idx_ready),
        .idx       (idx),
        .idx_valid (idx_valid),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
`ifdef LOOP_NEST_COUNTER_FLAT_EN
        ,
        .flat_idx  (flat_idx)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [NW-1:0] t;
        logic [N-1:0]  w;
        int            k;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string         name;
        logic [NW-1:0] bnd;
        int            ready_pct;
        int            exp_tuples;
        int            abort_after;
        bit            restart;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference ordering: plain nested loops, innermost dim fastest.
    task automatic push_expected(input logic [NW-1:0] bnd);
        int   b[N];
        int   k;
        exp_t e;
        for (int d = 0; d < N; d++) b[d] = int'(bnd[d*W +: W]);
        k = 0;
        for (int i3 = 0; i3 <= b[3]; i3++)
            for (int i2 = 0; i2 <= b[2]; i2++)
                for (int i1 = 0; i1 <= b[1]; i1++)
                    for (int i0 = 0; i0 <= b[0]; i0++) begin
                        e.t    = {W'(i3), W'(i2), W'(i1), W'(i0)};
                        e.w[0] = (i0 == b[0]);
                        e.w[1] = e.w[0] && (i1 == b[1]);
                        e.w[2] = e.w[1] && (i2 == b[2]);
                        e.w[3] = e.w[2] && (i3 == b[3]);
                        e.k    = k;
                        k++;
                        sb.push_back(e);
                    end
    endtask

    // Entered and left at a negedge with inputs stable.
    task automatic run_nest(input vec_t v);
        exp_t e;
        int   beats;
        int   cyc;
        bit   fin;
        sb.delete();
        push_expected(v.bnd);
        bound     = v.bnd;
        start     = 1'b1;
        idx_ready = 1'b0;
        @(negedge clk);
        beats = 0;
        fin   = 1'b0;
        cyc   = 0;
        while (!fin && cyc < 2000) begin
            cyc++;
            if (sb.size() == 0) begin
                chk({v.name, " queue_underflow"}, 64'(1), 64'(0));
                break;
            end
            e = sb[0];
            chk({v.name, " idx_valid"}, 64'(idx_valid), 64'(1));
            chk({v.name, " busy"}, 64'(busy), 64'(1));
            chk({v.name, " done_in_run"}, 64'(done), 64'(0));
            chk({v.name, " idx"}, 64'(idx), 64'(e.t));
            chk({v.name, " wrap"}, 64'(wrap), 64'(e.w));
`ifdef LOOP_NEST_COUNTER_FLAT_EN
            chk({v.name, " flat_idx"}, 64'(flat_idx), 64'(e.k));
`endif
            if (v.abort_after >= 0 && beats == v.abort_after) begin
                reset     = 1'b1;
                start     = 1'b0;
                idx_ready = 1'b1;
                @(negedge clk);
                reset     = 1'b0;
                idx_ready = 1'b0;
                chk({v.name, " abort_valid"}, 64'(idx_valid), 64'(0));
                chk({v.name, " abort_idx"}, 64'(idx), 64'(0));
                chk({v.name, " abort_busy"}, 64'(busy), 64'(0));
                chk({v.name, " abort_done"}, 64'(done), 64'(0));
                chk({v.name, " abort_wrap"}, 64'(wrap), 64'(0));
                @(negedge clk);
                chk({v.name, " abort_done2"}, 64'(done), 64'(0));
                chk({v.name, " abort_valid2"}, 64'(idx_valid), 64'(0));
                sb.delete();
                return;
            end
            // start and bound noise during RUN must be ignored.
            idx_ready = (int'($urandom_range(99)) < v.ready_pct);
            start     = 1'($urandom_range(1));
            bound     = NW'($urandom);
            if (idx_ready) begin
                beats++;
                fin = e.w[N-1];
                void'(sb.pop_front());
            end
            @(negedge clk);
        end
        if (!fin) chk({v.name, " final_beat_timeout"}, 64'(0), 64'(1));
        idx_ready = 1'b0;
        start     = v.restart;
        bound     = '0;
        chk({v.name, " done_pulse"}, 64'(done), 64'(1));
        chk({v.name, " end_valid"}, 64'(idx_valid), 64'(0));
        chk({v.name, " end_busy"}, 64'(busy), 64'(0));
        chk({v.name, " end_idx"}, 64'(idx), 64'(0));
        chk({v.name, " end_wrap"}, 64'(wrap), 64'(0));
        chk({v.name, " tuple_count"}, 64'(beats), 64'(v.exp_tuples));
        chk({v.name, " leftover"}, 64'(sb.size()), 64'(0));
`ifdef LOOP_NEST_COUNTER_FLAT_EN
        chk({v.name, " end_flat"}, 64'(flat_idx), 64'(0));
`endif
        @(negedge clk);
        start = 1'b0;
        if (v.restart) begin
            // Start taken on the done cycle: first tuple of an all-zero nest.
            chk({v.name, " restart_valid"}, 64'(idx_valid), 64'(1));
            chk({v.name, " restart_idx"}, 64'(idx), 64'(0));
            chk({v.name, " restart_wrap"}, 64'(wrap), 64'(4'hF));
            chk({v.name, " restart_done_low"}, 64'(done), 64'(0));
            idx_ready = 1'b1;
            @(negedge clk);
            idx_ready = 1'b0;
            chk({v.name, " restart_done"}, 64'(done), 64'(1));
            chk({v.name, " restart_end_valid"}, 64'(idx_valid), 64'(0));
            @(negedge clk);
        end
        chk({v.name, " done_one_cycle"}, 64'(done), 64'(0));
        chk({v.name, " idle_valid"}, 64'(idx_valid), 64'(0));
    endtask

    initial begin
        vecs[0] = '{"basic_r100", {8'd1, 8'd2, 8'd0, 8'd3}, 100, 24, -1, 1'b0};
        vecs[1] = '{"basic_r50", {8'd1, 8'd2, 8'd0, 8'd3}, 50, 24, -1, 1'b0};
        vecs[2] = '{"mixed_r70", {8'd2, 8'd1, 8'd1, 8'd1}, 70, 24, -1, 1'b0};
        vecs[3] = '{"all_zero", {8'd0, 8'd0, 8'd0, 8'd0}, 100, 1, -1, 1'b1};
        vecs[4] = '{"max_dim0", {8'd0, 8'd0, 8'd0, 8'd255}, 100, 256, -1, 1'b0};
        vecs[5] = '{"abort_at5", {8'd1, 8'd2, 8'd0, 8'd3}, 100, 24, 5, 1'b0};
        vecs[6] = '{"after_abort", {8'd1, 8'd2, 8'd0, 8'd3}, 80, 24, -1, 1'b0};

        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_valid", 64'(idx_valid), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_done", 64'(done), 64'(0));
            chk("idle_idx", 64'(idx), 64'(0));
            chk("idle_wrap", 64'(wrap), 64'(0));
        end

        for (int i = 0; i < 7; i++) begin
            run_nest(vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
